// File: rtl/polyphase_decim_fir.sv
// Decimating FIR with one time-shared MAC: collects DECIM samples, then runs TAPS MAC cycles and holds the result.
// Define POLY_FIR_SAT_EN to saturate the output and enable the sticky overflow flag (default: wrap, overflow tied 0).
module polyphase_decim_fir #(
  parameter int DATA_W    = 16,
  parameter int COEF_W    = 16,
  parameter int TAPS      = 32,
  parameter int DECIM     = 2,
  parameter int OUT_SHIFT = 15
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     coef_we,
  input  logic [$clog2(TAPS)-1:0]  coef_addr,
  input  logic signed [COEF_W-1:0] coef_data,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic signed [DATA_W-1:0] s_data,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic signed [DATA_W-1:0] m_data,
  output logic                     busy,
  output logic                     overflow
);

  localparam int ACC_W = DATA_W + COEF_W + $clog2(TAPS);
  localparam int AW    = $clog2(TAPS);
  localparam int PW    = DATA_W + COEF_W;
  localparam int PH_W  = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam logic signed [ACC_W-1:0] RND_HALF = ACC_W'(1) <<< (OUT_SHIFT - 1);

  typedef enum logic [1:0] {COLLECT, MAC, OUT} state_t;

  state_t                   state, state_nxt;
  logic [PH_W-1:0]          phase;
  logic [AW-1:0]            k;
  logic signed [DATA_W-1:0] x    [TAPS];
  logic signed [COEF_W-1:0] coef [TAPS];
  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  acc_fin;
  logic signed [PW-1:0]     prod_p0;
  logic                     vld_p0;
  logic                     accept;
  logic                     last_sample;
  logic                     last_tap;

  function automatic logic signed [ACC_W-1:0] round_shift(input logic signed [ACC_W-1:0] a);
    logic signed [ACC_W-1:0] t;
    t = a + RND_HALF;
    return t >>> OUT_SHIFT;
  endfunction

`ifdef POLY_FIR_SAT_EN
  localparam logic signed [ACC_W-1:0] SAT_MAX = (ACC_W'(1) <<< (DATA_W - 1)) - ACC_W'(1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = -SAT_MAX - ACC_W'(1);

  function automatic logic out_of_range(input logic signed [ACC_W-1:0] r);
    return (r > SAT_MAX) || (r < SAT_MIN);
  endfunction

  function automatic logic signed [DATA_W-1:0] narrow(input logic signed [ACC_W-1:0] r);
    if (r > SAT_MAX)      return {1'b0, {(DATA_W-1){1'b1}}};
    else if (r < SAT_MIN) return {1'b1, {(DATA_W-1){1'b0}}};
    else                  return r[DATA_W-1:0];
  endfunction
`else
  function automatic logic signed [DATA_W-1:0] narrow(input logic signed [ACC_W-1:0] r);
    return r[DATA_W-1:0];
  endfunction
`endif

  assign accept      = s_valid && s_ready;
  assign last_sample = (phase == PH_W'(DECIM - 1));
  assign last_tap    = (k == AW'(TAPS - 1));
  assign acc_fin     = acc + {{(ACC_W-PW){prod_p0[PW-1]}}, prod_p0};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= COLLECT;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      COLLECT: if (accept && last_sample) state_nxt = MAC;
      MAC:     if (last_tap)              state_nxt = OUT;
      OUT:     if (m_valid && m_ready)    state_nxt = COLLECT;
      default:                            state_nxt = COLLECT;
    endcase
  end

  always_comb begin
    s_ready = (state == COLLECT);
    busy    = (state == MAC) || (state == OUT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase   <= '0;
      k       <= '0;
      vld_p0  <= 1'b0;
      m_valid <= 1'b0;
    end else begin
      case (state)
        COLLECT: begin
          k <= '0;
          if (accept) phase <= last_sample ? '0 : phase + PH_W'(1);
        end
        MAC: begin
          k      <= k + AW'(1);
          vld_p0 <= 1'b1;
        end
        OUT: begin
          vld_p0 <= 1'b0;
          if (vld_p0)                   m_valid <= 1'b1;
          else if (m_valid && m_ready)  m_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Delay line and coefficient store; coefficient writes only land while collecting
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < TAPS; i++) begin
        x[i]    <= '0;
        coef[i] <= '0;
      end
    end else begin
      if (accept) begin
        for (int i = TAPS - 1; i > 0; i--) x[i] <= x[i-1];
        x[0] <= s_data;
      end
      if (coef_we && state == COLLECT && int'(coef_addr) < TAPS)
        coef[coef_addr] <= coef_data;
    end
  end

  // Stage p0: one registered product per MAC cycle
  always_ff @(posedge clk) begin
    if (state == MAC) prod_p0 <= coef[k] * x[k];
  end

  // Stage p1: accumulate; the final product is folded in while loading the output register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc    <= '0;
      m_data <= '0;
    end else if (state == COLLECT && accept && last_sample) begin
      acc <= '0;
    end else if (state == MAC && vld_p0) begin
      acc <= acc_fin;
    end else if (state == OUT && vld_p0) begin
      m_data <= narrow(round_shift(acc_fin));
    end
  end

`ifdef POLY_FIR_SAT_EN
  logic ovf_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                                  ovf_q <= 1'b0;
    else if (state == OUT && vld_p0 && out_of_range(round_shift(acc_fin))) ovf_q <= 1'b1;
  end
  assign overflow = ovf_q;
`else
  assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_polyphase_decim_fir.sv
// Bench for polyphase_decim_fir: directed tables plus randomized pairs against a sum-of-products model.
module tb_polyphase_decim_fir;
  localparam int TAPS = 32;
  localparam int SH   = 15;
`ifdef POLY_FIR_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst;
  logic               coef_we;
  logic [4:0]         coef_addr;
  logic signed [15:0] coef_data;
  logic               s_valid, s_ready;
  logic signed [15:0] s_data;
  logic               m_valid, m_ready;
  logic signed [15:0] m_data;
  logic               busy, overflow;

  logic               c6_we;
  logic [1:0]         c6_addr;
  logic signed [15:0] c6_data;
  logic               s6_valid, s6_ready;
  logic signed [15:0] s6_data;
  logic               m6_valid, m6_ready;
  logic signed [15:0] m6_data;
  logic               busy6, ovf6;

  polyphase_decim_fir dut (
    .clk(clk), .rst(rst), .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .busy(busy), .overflow(overflow)
  );

  polyphase_decim_fir #(.DATA_W(16), .COEF_W(16), .TAPS(4), .DECIM(1), .OUT_SHIFT(15)) dut6 (
    .clk(clk), .rst(rst), .coef_we(c6_we), .coef_addr(c6_addr), .coef_data(c6_data),
    .s_valid(s6_valid), .s_ready(s6_ready), .s_data(s6_data),
    .m_valid(m6_valid), .m_ready(m6_ready), .m_data(m6_data),
    .busy(busy6), .overflow(ovf6)
  );

  int checks = 0;
  int errors = 0;

  longint ref_coef [TAPS];
  longint ref_hist [TAPS];
  bit     ref_ovf;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  function automatic void model_push(input longint d);
    for (int i = TAPS - 1; i > 0; i--) ref_hist[i] = ref_hist[i-1];
    ref_hist[0] = d;
  endfunction

  function automatic longint model_out();
    longint acc, r;
    logic [15:0] w;
    acc = 0;
    for (int i = 0; i < TAPS; i++) acc += ref_coef[i] * ref_hist[i];
    r = (acc + (longint'(1) << (SH - 1))) >>> SH;
    if (SAT) begin
      if (r > 32767)       begin ref_ovf = 1'b1; r = 32767;  end
      else if (r < -32768) begin ref_ovf = 1'b1; r = -32768; end
    end else begin
      w = r[15:0];
      r = longint'($signed(w));
    end
    return r;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < TAPS; i++) begin
      ref_coef[i] = 0;
      ref_hist[i] = 0;
    end
    ref_ovf = 1'b0;
  endfunction

  task automatic wcoef(input int a, input longint v, input bit lands);
    coef_we = 1'b1; coef_addr = a[4:0]; coef_data = v[15:0];
    @(posedge clk); #1;
    coef_we = 1'b0;
    if (lands) ref_coef[a] = v;
  endtask

  task automatic push(input logic signed [15:0] d);
    int n = 0;
    s_valid = 1'b1; s_data = d;
    while (!s_ready && n < 100) begin @(posedge clk); #1; n++; end
    chk("push_ready", s_ready, 1);
    @(posedge clk); #1;
    s_valid = 1'b0;
    model_push(d);
  endtask

  task automatic pop(output logic signed [15:0] d, output int lat, input int hold);
    lat = 0;
    while (!m_valid && lat < 200) begin @(posedge clk); #1; lat++; end
    chk("m_valid_seen", m_valid, 1);
    d = m_data;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk("hold_valid", m_valid, 1);
      chk("hold_data", m_data, d);
      chk("hold_s_ready", s_ready, 0);
    end
    m_ready = 1'b1;
    @(posedge clk); #1;
    m_ready = 1'b0;
    chk("m_valid_drop", m_valid, 0);
  endtask

  task automatic pair_check(input string nm, input logic signed [15:0] a, input logic signed [15:0] b,
                            input int hold, output logic signed [15:0] got);
    longint expv;
    int lat;
    push(a);
    push(b);
    expv = model_out();
    chk("busy_in_mac", busy, 1);
    pop(got, lat, hold);
    chk(nm, got, expv);
    chk("latency", lat, TAPS + 1);
    chk("overflow_flag", overflow, ref_ovf);
  endtask

  typedef struct {
    logic signed [15:0] a;
    logic signed [15:0] b;
    logic signed [15:0] exp;
  } vec_t;
  vec_t tbl [17];

  initial begin
    #5ms;
    $display("FAIL watchdog: time limit reached, checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    logic signed [15:0] got;
    longint expv, sum6;
    longint hist6 [4];
    int lat, n;
    logic signed [15:0] ramp [10];

    for (int i = 0; i < 17; i++) begin
      tbl[i].a   = (i == 0) ? 16'sd16384 : 16'sd0;
      tbl[i].b   = 16'sd0;
      tbl[i].exp = (i < 16) ? 16'(1000 * (i + 1)) : 16'sd0;
    end

    rst = 1'b1; coef_we = 0; coef_addr = 0; coef_data = 0;
    s_valid = 0; s_data = 0; m_ready = 0;
    c6_we = 0; c6_addr = 0; c6_data = 0; s6_valid = 0; s6_data = 0; m6_ready = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("rst_s_ready", s_ready, 1);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst6_s_ready", s6_ready, 1);
    @(posedge clk); #1;

    // Impulse
    for (int i = 0; i < TAPS; i++) wcoef(i, 1000 * (i + 1), 1'b1);
    for (int i = 0; i < 17; i++) begin
      push(tbl[i].a);
      push(tbl[i].b);
      pop(got, lat, 0);
      chk("impulse", got, tbl[i].exp);
      chk("impulse_latency", lat, TAPS + 1);
    end

    // Backpressure
    for (int i = 0; i < 3; i++)
      pair_check("backpressure", 16'($urandom), 16'($urandom), 5, got);

    // Coefficient write during MAC is dropped
    push(16'($urandom));
    push(16'(1000 + $urandom_range(0, 20000)));
    expv = model_out();
    wcoef(0, 0, 1'b0);
    pop(got, lat, 0);
    chk("coef_in_mac_current", got, expv);
    pair_check("coef_in_mac_next", 16'($urandom), 16'(1000 + $urandom_range(0, 20000)), 0, got);

    // Randomized coefficients and samples
    for (int i = 0; i < TAPS; i++) wcoef(i, longint'($signed(16'($urandom))), 1'b1);
    for (int i = 0; i < 20; i++)
      pair_check("random", 16'($urandom), 16'($urandom), $urandom_range(0, 3), got);

    // Overflow
    for (int i = 0; i < TAPS; i++) wcoef(i, 32767, 1'b1);
    for (int i = 0; i < 16; i++) pair_check("overflow_seq", 16'sd32767, 16'sd32767, 0, got);
    chk("overflow_final_data", got, SAT ? 32767 : -64);
    chk("overflow_final_flag", overflow, SAT ? 1 : 0);

    // Reset mid-MAC
    push(16'($urandom));
    push(16'($urandom));
    repeat (5) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_m_valid", m_valid, 0);
    chk("midrst_s_ready", s_ready, 1);
    chk("midrst_busy", busy, 0);
    chk("midrst_overflow", overflow, 0);
    @(posedge clk); #1 rst = 1'b0;
    model_reset();
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (m_valid) n++;
    end
    chk("midrst_no_output", n, 0);
    pair_check("after_rst", 16'($urandom), 16'($urandom), 0, got);
    chk("after_rst_zero", got, 0);

    // DECIM=1, TAPS=4 moving average
    for (int i = 0; i < 4; i++) begin
      c6_we = 1'b1; c6_addr = 2'(i); c6_data = 16'sd8192;
      @(posedge clk); #1;
      c6_we = 1'b0;
      hist6[i] = 0;
    end
    for (int i = 0; i < 7; i++) ramp[i] = 16'(4096 * (i + 1));
    ramp[7] = -16'sd8192; ramp[8] = -16'sd30000; ramp[9] = -16'sd1;
    for (int i = 0; i < 10; i++) begin
      s6_valid = 1'b1; s6_data = ramp[i];
      n = 0;
      while (!s6_ready && n < 50) begin @(posedge clk); #1; n++; end
      chk("d1_push_ready", s6_ready, 1);
      @(posedge clk); #1;
      s6_valid = 1'b0;
      for (int j = 3; j > 0; j--) hist6[j] = hist6[j-1];
      hist6[0] = ramp[i];
      sum6 = hist6[0] + hist6[1] + hist6[2] + hist6[3];
      expv = (sum6 + 2) >>> 2;
      lat = 0;
      while (!m6_valid && lat < 50) begin @(posedge clk); #1; lat++; end
      chk("d1_latency", lat, 5);
      chk("d1_moving_avg", m6_data, expv);
      m6_ready = 1'b1;
      @(posedge clk); #1;
      m6_ready = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
